// File: rtl/fpu_shift_pkg.sv
// Shared types and widths for the FP add/sub alignment shifter.
package fpu_shift_pkg;
  localparam int FRAC_W   = 26;
  localparam int STEP_DEF = 4;
  localparam int AMT_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_t;
endpackage

// File: rtl/right_shift_step.sv
// One combinational right-shift step by k (0..STEP) with the OR of the bits dropped off the LSB end.
module right_shift_step #(
  parameter int WIDTH = 26,
  parameter int STEP  = 4,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] shifted,
  output logic             part_sticky
);
  logic [WIDTH-1:0] drop_mask;

  always_comb begin
    drop_mask   = ~({WIDTH{1'b1}} << k);
    shifted     = data >> k;
    part_sticky = |(data & drop_mask);
  end
endmodule

// File: rtl/right_shift_align.sv
// Sequential alignment shifter: right-shifts a fraction by up to STEP bits per cycle, collecting sticky.
// Handshake: a transfer happens on a rising edge where valid && ready are both high; in_ready is high
// only in IDLE, out_valid only in DONE, and out_valid stays up with stable data until out_ready.
module right_shift_align
  import fpu_shift_pkg::*;
#(
  parameter int WIDTH = FRAC_W,
  parameter int STEP  = STEP_DEF
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   fraction,
  input  logic [AMT_W-1:0]   shift_amount,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               sticky,
  output logic [AMT_W-1:0]   applied_amount,
  output align_state_t       state
);
  localparam int KW = $clog2(STEP + 1);

  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] rem_q;
  logic [AMT_W-1:0] amt_q;
  logic             sticky_acc_q;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] shifted;
  logic             part_sticky;

  // k = min(remaining, STEP); never exceeds remaining, so rem_q cannot underflow
  always_comb begin
    k = KW'(STEP);
    if (rem_q < AMT_W'(STEP)) k = rem_q[KW-1:0];
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  right_shift_step #(
    .WIDTH(WIDTH),
    .STEP (STEP),
    .KW   (KW)
  ) u_step (
    .data       (data_q),
    .k          (k),
    .shifted    (shifted),
    .part_sticky(part_sticky)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state          <= IDLE;
      data_q         <= '0;
      rem_q          <= '0;
      amt_q          <= '0;
      sticky_acc_q   <= 1'b0;
      result         <= '0;
      sticky         <= 1'b0;
      applied_amount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (shift_amount >= AMT_W'(WIDTH)) begin
              result         <= '0;
              sticky         <= |fraction;
              applied_amount <= AMT_W'(WIDTH);
              state          <= DONE;
            end else if (shift_amount == '0) begin
              result         <= fraction;
              sticky         <= 1'b0;
              applied_amount <= '0;
              state          <= DONE;
            end else begin
              data_q       <= fraction;
              rem_q        <= shift_amount;
              amt_q        <= shift_amount;
              sticky_acc_q <= 1'b0;
              state        <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q       <= shifted;
          rem_q        <= rem_q - AMT_W'(k);
          sticky_acc_q <= sticky_acc_q | part_sticky;
          // Visible outputs only change when the result is final
          if (rem_q == AMT_W'(k)) begin
            result         <= shifted;
            sticky         <= sticky_acc_q | part_sticky;
            applied_amount <= amt_q;
            state          <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_right_shift_align.sv
// Bench for right_shift_align: transaction-level reference model, per-cycle compare, directed and random traffic.
module tb_right_shift_align;
  import fpu_shift_pkg::*;

  localparam int W    = 26;
  localparam int STEP = 4;

  logic           CLK = 1'b0;
  logic           nRST = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   fraction = '0;
  logic [7:0]     shift_amount = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   result;
  logic           sticky;
  logic [7:0]     applied_amount;
  align_state_t   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  right_shift_align #(.WIDTH(W), .STEP(STEP)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .fraction      (fraction),
    .shift_amount  (shift_amount),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .sticky        (sticky),
    .applied_amount(applied_amount),
    .state         (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what a request must produce, from plain arithmetic.
  // off = number of cycles after the accept edge at which out_valid is first seen (T+off).
  typedef struct {
    logic [W-1:0] res;
    logic         st;
    logic [7:0]   ap;
    int           off;
  } exp_t;

  function automatic exp_t model(input logic [W-1:0] f, input logic [7:0] a);
    exp_t e;
    logic [63:0] wide;
    int amt;
    wide = 64'(f);
    amt  = int'(a);
    if (amt >= W) begin
      e.res = '0; e.st = |f; e.ap = 8'(W); e.off = 1;
    end else if (amt == 0) begin
      e.res = f; e.st = 1'b0; e.ap = 8'd0; e.off = 1;
    end else begin
      e.res = W'(wide >> amt);
      e.st  = |(wide & ((64'd1 << amt) - 64'd1));
      e.ap  = a;
      e.off = 1 + (amt + STEP - 1) / STEP;
    end
    return e;
  endfunction

  // Transaction-level model: one request in flight, result visible from accept + off.
  logic m_busy = 1'b0;
  int   cyc = 0;
  int   m_ready_at = 0;
  exp_t m_exp;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_busy <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (m_busy) begin
        if (cyc >= m_ready_at && out_ready) m_busy <= 1'b0;
      end else if (in_valid) begin
        m_busy     <= 1'b1;
        m_exp      <= model(fraction, shift_amount);
        m_ready_at <= cyc + model(fraction, shift_amount).off;
      end
    end
  end

  // Scoreboard compare, every cycle, away from the active edge
  always @(negedge CLK) begin
    logic exp_v;
    exp_v = m_busy && (cyc >= m_ready_at);
    check("in_ready", 64'(in_ready), 64'(!m_busy));
    check("out_valid", 64'(out_valid), 64'(exp_v));
    if (out_valid && exp_v) begin
      check("result", 64'(result), 64'(m_exp.res));
      check("sticky", 64'(sticky), 64'(m_exp.st));
      check("applied_amount", 64'(applied_amount), 64'(m_exp.ap));
    end
  end

  // Driver: called at a negedge; returns the observed offset of out_valid after the accept edge.
  task automatic send(input logic [W-1:0] f, input logic [7:0] a, input int hold, output int lat);
    int n;
    in_valid     = 1'b1;
    fraction     = f;
    shift_amount = a;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
    end
    @(negedge CLK);
    lat = 1;
    // inputs only matter at accept: scramble them while busy
    in_valid = 1'($urandom_range(0, 1)); fraction = W'($urandom()); shift_amount = 8'($urandom());
    while (!out_valid && lat < 100) begin
      @(negedge CLK);
      lat++;
      in_valid = 1'($urandom_range(0, 1)); fraction = W'($urandom()); shift_amount = 8'($urandom());
    end
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: out_valid stayed 0 expected 1");
    end
    repeat (hold) begin
      @(negedge CLK);
      in_valid = 1'b1; fraction = W'($urandom()); shift_amount = 8'($urandom());
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic directed(input string name, input logic [W-1:0] f, input logic [7:0] a, input int hold,
                          input logic [W-1:0] x_res, input logic x_st, input logic [7:0] x_ap, input int x_off);
    exp_t e;
    int lat;
    e = model(f, a);
    check({name, "_model_res"}, 64'(e.res), 64'(x_res));
    check({name, "_model_st"}, 64'(e.st), 64'(x_st));
    check({name, "_model_ap"}, 64'(e.ap), 64'(x_ap));
    check({name, "_model_off"}, 64'(e.off), 64'(x_off));
    send(f, a, hold, lat);
    check({name, "_latency"}, 64'(lat), 64'(x_off));
  endtask

  initial begin
    int lat;
    logic [W-1:0] f;
    logic [7:0] a;
    int sel;

    repeat (3) @(negedge CLK);
    check("rst_result", 64'(result), 64'd0);
    check("rst_sticky", 64'(sticky), 64'd0);
    check("rst_applied", 64'(applied_amount), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    nRST = 1'b1;
    @(negedge CLK);

    directed("amt5",   26'h2000001, 8'd5,  0, 26'h0100000, 1'b1, 8'd5,  3);
    directed("amt0",   26'h3FFFFFF, 8'd0,  0, 26'h3FFFFFF, 1'b0, 8'd0,  1);
    directed("amt40",  26'h0000001, 8'd40, 0, 26'h0000000, 1'b1, 8'd26, 1);
    directed("amt26",  26'h0000000, 8'd26, 0, 26'h0000000, 1'b0, 8'd26, 1);
    directed("amt25",  26'h3000000, 8'd25, 0, 26'h0000001, 1'b1, 8'd25, 8);
    directed("hold8",  26'h00001FF, 8'd8,  3, 26'h0000001, 1'b1, 8'd8,  3);
    directed("amt255", 26'h0000100, 8'd255,1, 26'h0000000, 1'b1, 8'd26, 1);

    // Reset in the middle of a long shift
    in_valid = 1'b1; fraction = 26'h3FFFFFF; shift_amount = 8'd20;
    @(negedge CLK);
    in_valid = 1'b0;
    @(negedge CLK);
    check("pre_rst_state", 64'(dbg_state), 64'(SHIFT));
    #1 nRST = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_state", 64'(dbg_state), 64'(IDLE));
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    repeat (10) @(negedge CLK);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 9));
      f = W'($urandom());
      if (sel == 0)      a = 8'd0;
      else if (sel == 1) a = 8'($urandom_range(26, 255));
      else if (sel == 2) a = 8'($urandom_range(25, 26));
      else               a = 8'($urandom_range(1, 25));
      send(f, a, int'($urandom_range(0, 3)), lat);
      check("rand_latency", 64'(lat), 64'(model(f, a).off));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end
endmodule
